// File: rtl/sdram_mc_arbiter_if.sv
// Bus bundle between the SDRAM arbiter, its requester channels and the SDRAM controller.
// master = arbiter side, slave = the surrounding controller/requester side.
interface sdram_mc_arbiter_if #(
  parameter int N_CH   = 4,
  parameter int ADDR_W = 24,
  parameter int DATA_W = 16
);
  localparam int MASK_W = DATA_W / 8;

  // controller side
  logic                     sdram_rd;
  logic                     sdram_wr;
  logic [ADDR_W-1:0]        sdram_addr_x16;
  logic [DATA_W-1:0]        sdram_wdata;
  logic [MASK_W-1:0]        sdram_wmask;
  logic                     sdram_burst;
  logic                     sdram_ack;
  logic                     sdram_rdy;
  logic                     sdram_resp_valid;
  logic [DATA_W-1:0]        sdram_rdata;

  // requester side, channel i packed at [i*W +: W]
  logic [N_CH-1:0]          ch_rd;
  logic [N_CH-1:0]          ch_wr;
  logic [N_CH*ADDR_W-1:0]   ch_addr_x16;
  logic [N_CH*DATA_W-1:0]   ch_wdata;
  logic [N_CH*MASK_W-1:0]   ch_wmask;
  logic [N_CH-1:0]          ch_ack;
  logic [N_CH-1:0]          ch_rdy;
  logic [N_CH-1:0]          ch_resp_valid;
  logic [DATA_W-1:0]        ch_rdata;

  modport master (
    output sdram_rd, sdram_wr, sdram_addr_x16, sdram_wdata, sdram_wmask,
    output sdram_burst, sdram_ack,
    input  sdram_rdy, sdram_resp_valid, sdram_rdata,
    input  ch_rd, ch_wr, ch_addr_x16, ch_wdata, ch_wmask, ch_ack,
    output ch_rdy, ch_resp_valid, ch_rdata
  );

  modport slave (
    input  sdram_rd, sdram_wr, sdram_addr_x16, sdram_wdata, sdram_wmask,
    input  sdram_burst, sdram_ack,
    output sdram_rdy, sdram_resp_valid, sdram_rdata,
    output ch_rd, ch_wr, ch_addr_x16, ch_wdata, ch_wmask, ch_ack,
    input  ch_rdy, ch_resp_valid, ch_rdata
  );
endinterface

// File: rtl/sdram_mc_arbiter.sv
// N-channel SDRAM arbiter: fixed priority for real-time channels, round-robin for the
// rest, with a starvation guard that forces a long-waiting non-RT channel through.
//
//   state   | meaning
//   --------+-----------------------------------------------------------------
//   S_IDLE  | no owner, all controller outputs 0; arbitration happens here only
//   S_OWNED | grant_q holds the owner; its signals are muxed until its ch_ack
module sdram_mc_arbiter #(
  parameter int              N_CH         = 4,
  parameter int              ADDR_W       = 24,
  parameter int              DATA_W       = 16,
  parameter int              WAITSTATES   = 2,
  parameter logic [N_CH-1:0] RT_MASK      = N_CH'(1),
  parameter logic [N_CH-1:0] BURST_MASK   = N_CH'(1),
  parameter int              STARVE_LIMIT = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  sdram_mc_arbiter_if.master    bus,
  output logic [N_CH-1:0]       grant_o
);

  localparam int MASK_W = DATA_W / 8;
  localparam int IDX_W  = $clog2(N_CH);
  localparam int CNT_W  = 3;
  localparam int ST_W   = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
  localparam logic [ST_W-1:0] ST_LIM = ST_W'(STARVE_LIMIT);

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_OWNED = 1'b1
  } state_t;

  state_t                     state_q, state_d;
  logic [N_CH-1:0]            grant_q, grant_d;
  logic [CNT_W-1:0]           cnt_q, cnt_d;
  logic [IDX_W-1:0]           rr_ptr_q, rr_ptr_d;
  logic [N_CH-1:0][ST_W-1:0]  starve_q, starve_d;

  logic [N_CH-1:0]            req;
  logic [N_CH-1:0]            nrt_req;
  logic                       ack_own;

  logic                       pick_vld;
  logic                       pick_rt;
  logic [IDX_W-1:0]           pick_idx;
  logic [N_CH-1:0]            pick_oh;
  logic                       rr_hi_vld, rr_lo_vld;
  logic [IDX_W-1:0]           rr_hi_idx, rr_lo_idx;

  // Burst channels only ever read, so their write strobe does not count as a request.
  assign req     = bus.ch_rd | (bus.ch_wr & ~BURST_MASK);
  assign nrt_req = req & ~RT_MASK;
  assign ack_own = |(grant_q & bus.ch_ack);

  // Winner selection; later stages override earlier ones, so the order below is
  // lowest to highest precedence: round-robin, real-time, starved.
  always_comb begin
    pick_vld  = 1'b0;
    pick_rt   = 1'b0;
    pick_idx  = '0;
    rr_hi_vld = 1'b0;
    rr_hi_idx = '0;
    rr_lo_vld = 1'b0;
    rr_lo_idx = '0;

    for (int i = 0; i < N_CH; i++) begin
      if (!rr_hi_vld && nrt_req[i] && (IDX_W'(i) > rr_ptr_q)) begin
        rr_hi_vld = 1'b1;
        rr_hi_idx = IDX_W'(i);
      end
      if (!rr_lo_vld && nrt_req[i]) begin
        rr_lo_vld = 1'b1;
        rr_lo_idx = IDX_W'(i);
      end
    end
    if (rr_hi_vld || rr_lo_vld) begin
      pick_vld = 1'b1;
      pick_idx = rr_hi_vld ? rr_hi_idx : rr_lo_idx;
    end

    for (int i = N_CH - 1; i >= 0; i--) begin
      if (RT_MASK[i] && req[i]) begin
        pick_vld = 1'b1;
        pick_rt  = 1'b1;
        pick_idx = IDX_W'(i);
      end
    end

    if (STARVE_LIMIT != 0) begin
      for (int i = N_CH - 1; i >= 0; i--) begin
        if (nrt_req[i] && (starve_q[i] >= ST_LIM)) begin
          pick_vld = 1'b1;
          pick_rt  = 1'b0;
          pick_idx = IDX_W'(i);
        end
      end
    end

    pick_oh = '0;
    for (int i = 0; i < N_CH; i++) begin
      pick_oh[i] = pick_vld && (pick_idx == IDX_W'(i));
    end
  end

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    cnt_d    = cnt_q;
    rr_ptr_d = rr_ptr_q;

    case (state_q)
      S_IDLE: begin
        if (pick_vld) begin
          state_d = S_OWNED;
          grant_d = pick_oh;
          cnt_d   = CNT_W'(WAITSTATES);
          if (!pick_rt) begin
            rr_ptr_d = pick_idx;
          end
        end
      end
      S_OWNED: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end
        if (ack_own) begin
          state_d = S_IDLE;
          grant_d = '0;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = S_IDLE;
        grant_d = '0;
        cnt_d   = '0;
      end
    endcase
  end

  // RT channels and idle channels never accumulate wait credit.
  always_comb begin
    starve_d = starve_q;
    for (int i = 0; i < N_CH; i++) begin
      if (!nrt_req[i]) begin
        starve_d[i] = '0;
      end else if ((state_q == S_IDLE) && pick_vld) begin
        if (pick_oh[i]) begin
          starve_d[i] = '0;
        end else if (starve_q[i] < ST_LIM) begin
          starve_d[i] = starve_q[i] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= S_IDLE;
      grant_q  <= '0;
      cnt_q    <= '0;
      rr_ptr_q <= '0;
      starve_q <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      cnt_q    <= cnt_d;
      rr_ptr_q <= rr_ptr_d;
      starve_q <= starve_d;
    end
  end

  // AND-OR mux keyed on the one-hot grant; all zero when nobody owns the port.
  always_comb begin
    bus.sdram_rd       = 1'b0;
    bus.sdram_wr       = 1'b0;
    bus.sdram_addr_x16 = '0;
    bus.sdram_wdata    = '0;
    bus.sdram_wmask    = '0;
    bus.sdram_burst    = 1'b0;
    bus.sdram_ack      = 1'b0;
    for (int i = 0; i < N_CH; i++) begin
      if (grant_q[i]) begin
        bus.sdram_rd       = bus.ch_rd[i];
        bus.sdram_wr       = bus.ch_wr[i] & ~BURST_MASK[i];
        bus.sdram_addr_x16 = bus.ch_addr_x16[i*ADDR_W +: ADDR_W];
        bus.sdram_wdata    = bus.ch_wdata[i*DATA_W +: DATA_W];
        bus.sdram_wmask    = bus.ch_wmask[i*MASK_W +: MASK_W];
        bus.sdram_burst    = BURST_MASK[i];
        bus.sdram_ack      = bus.ch_ack[i];
      end
    end
  end

  assign bus.ch_rdy        = grant_q & {N_CH{(cnt_q == '0) && bus.sdram_rdy}};
  assign bus.ch_resp_valid = grant_q & {N_CH{bus.sdram_resp_valid}};
  assign bus.ch_rdata      = bus.sdram_rdata;
  assign grant_o           = grant_q;

  a_grant_onehot: assert property (@(posedge clk_i) disable iff (rst_i)
    $onehot0(grant_q));
  a_state_grant: assert property (@(posedge clk_i) disable iff (rst_i)
    (state_q == S_IDLE) == (grant_q == '0));

endmodule

// File: tb/tb_sdram_mc_arbiter.sv
// Directed bench for sdram_mc_arbiter: reset, waitstates, round-robin, starvation guard,
// ownership persistence and data/mask/burst muxing, with hand-computed expectations.
module tb_sdram_mc_arbiter;

  localparam int N_CH   = 4;
  localparam int ADDR_W = 24;
  localparam int DATA_W = 16;

  logic            clk_i = 1'b0;
  logic            rst_i = 1'b1;
  logic [N_CH-1:0] grant_o;

  int n_chk = 0;
  int n_err = 0;

  sdram_mc_arbiter_if #(.N_CH(N_CH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  sdram_mc_arbiter #(
    .N_CH         (N_CH),
    .ADDR_W       (ADDR_W),
    .DATA_W       (DATA_W),
    .WAITSTATES   (2),
    .RT_MASK      (4'b0001),
    .BURST_MASK   (4'b0001),
    .STARVE_LIMIT (8)
  ) dut (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .bus     (bus),
    .grant_o (grant_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic do_reset();
    rst_i                = 1'b1;
    bus.ch_rd            = '0;
    bus.ch_wr            = '0;
    bus.ch_ack           = '0;
    bus.sdram_rdy        = 1'b1;
    bus.sdram_resp_valid = 1'b0;
    tick();
    tick();
    rst_i = 1'b0;
  endtask

  logic [3:0] rr_exp [6] = '{4'b0010, 4'b0100, 4'b1000, 4'b0010, 4'b0100, 4'b1000};

  initial begin
    bus.ch_rd            = '0;
    bus.ch_wr            = '0;
    bus.ch_ack           = '0;
    bus.ch_addr_x16      = '0;
    bus.ch_wdata         = '0;
    bus.ch_wmask         = '0;
    bus.sdram_rdy        = 1'b0;
    bus.sdram_resp_valid = 1'b0;
    bus.sdram_rdata      = '0;

    bus.ch_addr_x16[0*ADDR_W +: ADDR_W] = 24'h000100;
    bus.ch_addr_x16[1*ADDR_W +: ADDR_W] = 24'h000200;
    bus.ch_addr_x16[2*ADDR_W +: ADDR_W] = 24'h000300;
    bus.ch_addr_x16[3*ADDR_W +: ADDR_W] = 24'h123456;

    // Reset held with every channel requesting
    rst_i     = 1'b1;
    bus.ch_rd = 4'b1111;
    tick();
    tick();
    tick();
    check_val("rst_grant", grant_o, 4'b0000);
    check_val("rst_rd", bus.sdram_rd, 1'b0);
    check_val("rst_wr", bus.sdram_wr, 1'b0);
    check_val("rst_addr", bus.sdram_addr_x16, 24'h0);
    check_val("rst_burst", bus.sdram_burst, 1'b0);
    check_val("rst_ch_rdy", bus.ch_rdy, 4'b0000);
    rst_i = 1'b0;
    tick();
    check_val("rel_grant", grant_o, 4'b0001);
    check_val("rel_rd", bus.sdram_rd, 1'b1);
    check_val("rel_addr", bus.sdram_addr_x16, 24'h000100);
    check_val("rel_burst", bus.sdram_burst, 1'b1);
    // Reset mid-transaction drops ownership on the next edge
    rst_i = 1'b1;
    tick();
    check_val("midrst_grant", grant_o, 4'b0000);
    check_val("midrst_rd", bus.sdram_rd, 1'b0);

    // Waitstates: ch1 read issued at t=0
    do_reset();
    bus.ch_rd = 4'b0010;
    check_val("ws_t0_grant", grant_o, 4'b0000);
    tick();
    check_val("ws_t1_grant", grant_o, 4'b0010);
    check_val("ws_t1_rdy", bus.ch_rdy, 4'b0000);
    check_val("ws_t1_addr", bus.sdram_addr_x16, 24'h000200);
    check_val("ws_t1_burst", bus.sdram_burst, 1'b0);
    tick();
    check_val("ws_t2_rdy", bus.ch_rdy, 4'b0000);
    tick();
    check_val("ws_t3_rdy", bus.ch_rdy, 4'b0010);
    bus.sdram_rdy = 1'b0;
    #1;
    check_val("ws_t3_rdy_low", bus.ch_rdy, 4'b0000);
    tick();
    bus.sdram_rdy        = 1'b1;
    bus.sdram_resp_valid = 1'b1;
    #1;
    check_val("ws_t4_rdy", bus.ch_rdy, 4'b0010);
    check_val("ws_t4_resp", bus.ch_resp_valid, 4'b0010);
    bus.sdram_resp_valid = 1'b0;
    tick();
    bus.ch_ack = 4'b0010;
    bus.ch_rd  = 4'b0000;
    #1;
    check_val("ws_t5_grant", grant_o, 4'b0010);
    check_val("ws_t5_ack", bus.sdram_ack, 1'b1);
    tick();
    bus.ch_ack = 4'b0000;
    check_val("ws_t6_grant", grant_o, 4'b0000);
    check_val("ws_t6_rd", bus.sdram_rd, 1'b0);

    // Round-robin among non-RT channels 1..3
    do_reset();
    bus.ch_rd = 4'b1110;
    for (int k = 0; k < 6; k++) begin
      tick();
      check_val($sformatf("rr_grant_%0d", k), grant_o, rr_exp[k]);
      bus.ch_ack = rr_exp[k];
      tick();
      check_val($sformatf("rr_bubble_%0d", k), grant_o, 4'b0000);
      bus.ch_ack = 4'b0000;
    end
    bus.ch_rd = 4'b0000;
    tick();

    // Starvation guard: ch2 wins after exactly 8 ch0 grants
    do_reset();
    bus.ch_rd = 4'b0101;
    for (int k = 0; k < 9; k++) begin
      tick();
      check_val($sformatf("stv_grant_%0d", k), grant_o, (k < 8) ? 4'b0001 : 4'b0100);
      if (k < 8) begin
        bus.ch_ack = 4'b0001;
        tick();
        bus.ch_ack = 4'b0000;
      end
    end

    // ch2 keeps ownership after dropping rd; non-owner ack ignored
    bus.ch_rd  = 4'b0001;
    bus.ch_ack = 4'b0001;
    for (int k = 0; k < 10; k++) begin
      tick();
      check_val($sformatf("hold_grant_%0d", k), grant_o, 4'b0100);
      check_val($sformatf("hold_rd_%0d", k), bus.sdram_rd, 1'b0);
      check_val($sformatf("hold_ack_%0d", k), bus.sdram_ack, 1'b0);
    end
    bus.ch_ack = 4'b0100;
    #1;
    check_val("hold_own_ack", bus.sdram_ack, 1'b1);
    tick();
    bus.ch_ack = 4'b0000;
    check_val("hold_bubble", grant_o, 4'b0000);
    tick();
    check_val("hold_next_grant", grant_o, 4'b0001);
    bus.ch_ack = 4'b0001;
    bus.ch_rd  = 4'b0000;
    tick();
    bus.ch_ack = 4'b0000;

    // Write data/mask muxing, burst flag, rdata broadcast
    do_reset();
    bus.ch_wdata[3*DATA_W +: DATA_W] = 16'hBEEF;
    bus.ch_wmask[3*2 +: 2]           = 2'b01;
    bus.ch_wdata[0*DATA_W +: DATA_W] = 16'h1234;
    bus.ch_wmask[0*2 +: 2]           = 2'b11;
    bus.ch_wr = 4'b1000;
    tick();
    check_val("wr_grant", grant_o, 4'b1000);
    check_val("wr_wr", bus.sdram_wr, 1'b1);
    check_val("wr_rd", bus.sdram_rd, 1'b0);
    check_val("wr_wdata", bus.sdram_wdata, 16'hBEEF);
    check_val("wr_wmask", bus.sdram_wmask, 2'b01);
    check_val("wr_burst", bus.sdram_burst, 1'b0);
    check_val("wr_addr", bus.sdram_addr_x16, 24'h123456);
    bus.sdram_rdata      = 16'h5A5A;
    bus.sdram_resp_valid = 1'b1;
    #1;
    check_val("wr_rdata", bus.ch_rdata, 16'h5A5A);
    check_val("wr_resp", bus.ch_resp_valid, 4'b1000);
    bus.sdram_resp_valid = 1'b0;
    bus.ch_ack = 4'b1000;
    bus.ch_wr  = 4'b0000;
    tick();
    bus.ch_ack = 4'b0000;
    check_val("idle_wdata", bus.sdram_wdata, 16'h0);
    check_val("idle_wmask", bus.sdram_wmask, 2'b00);
    check_val("idle_addr", bus.sdram_addr_x16, 24'h0);
    bus.ch_rd = 4'b0001;
    bus.ch_wr = 4'b0001;
    tick();
    check_val("br_grant", grant_o, 4'b0001);
    check_val("br_burst", bus.sdram_burst, 1'b1);
    check_val("br_rd", bus.sdram_rd, 1'b1);
    check_val("br_wr", bus.sdram_wr, 1'b0);
    bus.sdram_rdata = 16'hC3C3;
    #1;
    check_val("br_rdata", bus.ch_rdata, 16'hC3C3);
    bus.ch_ack = 4'b0001;
    bus.ch_rd  = 4'b0000;
    bus.ch_wr  = 4'b0000;
    tick();
    bus.ch_ack = 4'b0000;
    check_val("br_end_grant", grant_o, 4'b0000);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
